// File: rtl/key_if_pkg.sv
// rtl/key_if_pkg.sv - shared widths, FSM encoding and cache line type for the key lookup cache
package key_if_pkg;

    localparam int KEY_ID_W = 32;
    localparam int KEY_W    = 256;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOOKUP  = 2'd1;
    localparam logic [1:0] ST_FETCH   = 2'd2;
    localparam logic [1:0] ST_RESPOND = 2'd3;

    typedef struct packed {
        logic                valid;
        logic [KEY_ID_W-1:0] tag;
        logic [KEY_W-1:0]    key;
    } key_line_t;

endpackage

// File: rtl/key_cache_tag_match.sv
// rtl/key_cache_tag_match.sv - combinational compare of one id against all cache tags
module key_cache_tag_match
    import key_if_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic [KEY_ID_W-1:0]         id_i,
    input  logic [ENTRIES*KEY_ID_W-1:0] tags_i,
    input  logic [ENTRIES-1:0]          valids_i,
    output logic                        hit_o,
    output logic [IDX_W-1:0]            hit_idx_o
);

    // Fills only happen on a miss, so at most one line can match.
    always_comb begin
        hit_o     = 1'b0;
        hit_idx_o = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valids_i[i] && (tags_i[i*KEY_ID_W +: KEY_ID_W] == id_i)) begin
                hit_o     = 1'b1;
                hit_idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/key_lookup_cache.sv
// rtl/key_lookup_cache.sv - fully-associative key cache in front of keymem; KEY_CACHE_STATS_EN builds stat counters
module key_lookup_cache
    import key_if_pkg::*;
#(
    parameter int ENTRIES     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                key_clk,
    input  logic                key_aresetn,
    input  logic                req_key_req,
    input  logic [KEY_ID_W-1:0] req_key_id,
    output logic                req_key_ack,
    output logic [KEY_W-1:0]    req_key,
    output logic                req_key_err,
    output logic                mem_key_req,
    output logic [KEY_ID_W-1:0] mem_key_id,
    input  logic                mem_key_ack,
    input  logic [KEY_W-1:0]    mem_key,
    input  logic                cache_flush,
    output logic [31:0]         stat_hits,
    output logic [31:0]         stat_misses,
    output logic [31:0]         stat_timeouts
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [1:0]          state_q, state_d;
    logic [KEY_ID_W-1:0] id_q, id_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic                err_q, err_d;
    logic                flush_seen_q, flush_seen_d;
    logic [IDX_W-1:0]    rr_ptr_q;
    key_line_t           lines_q [ENTRIES];

    logic                        fill;
    logic                        timeout;
    logic                        hit;
    logic [IDX_W-1:0]            hit_idx;
    logic [ENTRIES*KEY_ID_W-1:0] tags_flat;
    logic [ENTRIES-1:0]          valids;

    always_comb begin
        tags_flat = '0;
        valids    = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            tags_flat[i*KEY_ID_W +: KEY_ID_W] = lines_q[i].tag;
            valids[i]                         = lines_q[i].valid;
        end
    end

    key_cache_tag_match #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_match (
        .id_i      (id_q),
        .tags_i    (tags_flat),
        .valids_i  (valids),
        .hit_o     (hit),
        .hit_idx_o (hit_idx)
    );

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        key_d        = key_q;
        err_d        = err_q;
        flush_seen_d = flush_seen_q;
        fill         = 1'b0;
        timeout      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_key_req) begin
                    id_d    = req_key_id;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (hit) begin
                    key_d   = lines_q[hit_idx].key;
                    err_d   = 1'b0;
                    state_d = ST_RESPOND;
                end else begin
                    cnt_d        = 16'(TIMEOUT_CYC - 1);
                    flush_seen_d = 1'b0;
                    state_d      = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (cache_flush) begin
                    flush_seen_d = 1'b1;
                end
                // A flush anywhere in the fetch window must keep the fetched key out of the cache.
                if (mem_key_ack) begin
                    key_d   = mem_key;
                    err_d   = 1'b0;
                    fill    = !(cache_flush || flush_seen_q);
                    state_d = ST_RESPOND;
                end else if (cnt_q == 16'd0) begin
                    key_d   = '0;
                    err_d   = 1'b1;
                    timeout = 1'b1;
                    state_d = ST_RESPOND;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge key_clk or negedge key_aresetn) begin
        if (!key_aresetn) begin
            state_q      <= ST_IDLE;
            id_q         <= '0;
            cnt_q        <= '0;
            key_q        <= '0;
            err_q        <= 1'b0;
            flush_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            key_q        <= key_d;
            err_q        <= err_d;
            flush_seen_q <= flush_seen_d;
        end
    end

    always_ff @(posedge key_clk or negedge key_aresetn) begin
        if (!key_aresetn) begin
            rr_ptr_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                lines_q[i] <= '0;
            end
        end else if (cache_flush) begin
            rr_ptr_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                lines_q[i].valid <= 1'b0;
            end
        end else if (fill) begin
            lines_q[rr_ptr_q] <= '{valid: 1'b1, tag: id_q, key: mem_key};
            rr_ptr_q          <= rr_ptr_q + IDX_W'(1);
        end
    end

    assign req_key_ack = (state_q == ST_RESPOND);
    assign req_key     = key_q;
    assign req_key_err = err_q;
    assign mem_key_req = (state_q == ST_FETCH);
    assign mem_key_id  = mem_key_req ? id_q : '0;

`ifdef KEY_CACHE_STATS_EN
    logic [31:0] hits_q, misses_q, timeouts_q;

    always_ff @(posedge key_clk or negedge key_aresetn) begin
        if (!key_aresetn) begin
            hits_q     <= '0;
            misses_q   <= '0;
            timeouts_q <= '0;
        end else begin
            if ((state_q == ST_LOOKUP) && hit && (hits_q != '1)) begin
                hits_q <= hits_q + 32'd1;
            end
            if ((state_q == ST_LOOKUP) && !hit && (misses_q != '1)) begin
                misses_q <= misses_q + 32'd1;
            end
            if (timeout && (timeouts_q != '1)) begin
                timeouts_q <= timeouts_q + 32'd1;
            end
        end
    end

    assign stat_hits     = hits_q;
    assign stat_misses   = misses_q;
    assign stat_timeouts = timeouts_q;
`else
    logic unused_timeout;
    assign unused_timeout = timeout;
    assign stat_hits      = 32'h0;
    assign stat_misses    = 32'h0;
    assign stat_timeouts  = 32'h0;
`endif

endmodule
